// File: rtl/serdesphy_link_seq.sv
// rtl/serdesphy_link_seq.sv - PHY link bring-up sequencer (iso, PLL, CDR, datapath)
// Optional ERROR auto-retry enabled by defining SERDESPHY_SEQ_AUTO_RETRY_EN.
`timescale 1ns/1ps
module serdesphy_link_seq #(
  parameter int unsigned RST_HOLD_CYCLES  = 16,
  parameter int unsigned LOCK_FILTER      = 8,
  parameter int unsigned PLL_LOCK_TIMEOUT = 4096,
  parameter int unsigned CDR_LOCK_TIMEOUT = 8192
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
  ,
  parameter int unsigned RETRY_LIMIT      = 3
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phy_en,
  input  logic       seq_restart,
  input  logic       tx_en_req,
  input  logic       rx_en_req,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  output logic       iso_out,
  output logic       pll_rst_out,
  output logic       cdr_rst_out,
  output logic       tx_path_en,
  output logic       rx_path_en,
  output logic       link_up,
  output logic [2:0] seq_state,
  output logic [1:0] err_code,
  output logic [7:0] relock_cnt
);

  localparam int unsigned MAX_A  = (PLL_LOCK_TIMEOUT > CDR_LOCK_TIMEOUT) ? PLL_LOCK_TIMEOUT : CDR_LOCK_TIMEOUT;
  localparam int unsigned MAX_T  = (MAX_A > RST_HOLD_CYCLES) ? MAX_A : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
  localparam int unsigned FLT_W  = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FLT_W-1:0] FLT_MAX  = '1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CDR_LAST = CNT_W'(CDR_LOCK_TIMEOUT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PLL_RST  = 3'd1,
    S_PLL_WAIT = 3'd2,
    S_CDR_RST  = 3'd3,
    S_CDR_WAIT = 3'd4,
    S_ACTIVE   = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FLT_W-1:0] pll_flt_q, pll_flt_d, cdr_flt_q, cdr_flt_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       relock_q, relock_d;
  logic             restart_hit;
  logic             pll_locked, cdr_locked, rst_done;
  logic             iso_q, pll_rst_q, cdr_rst_q, tx_en_q, rx_en_q, link_q;
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Filters only run while waiting for their own lock, so each wait starts unfiltered.
  assign pll_locked = pll_lock && (pll_flt_q >= FLT_LAST);
  assign cdr_locked = cdr_lock && (cdr_flt_q >= FLT_LAST);
  assign rst_done   = (cnt_q == RST_LAST);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    relock_d    = relock_q;
    restart_hit = 1'b0;
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
    retry_d     = retry_q;
`endif
    if (!phy_en) begin
      state_d = S_OFF;
    end else if (seq_restart && state_q != S_OFF) begin
      state_d     = S_PLL_RST;
      err_d       = 2'b00;
      restart_hit = 1'b1;
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
      retry_d     = 2'd0;
`endif
    end else begin
      case (state_q)
        S_OFF:      state_d = S_PLL_RST;
        S_PLL_RST:  if (rst_done) state_d = S_PLL_WAIT;
        S_PLL_WAIT: begin
          if (pll_locked) state_d = S_CDR_RST;
          else if (cnt_q == PLL_LAST) begin
            state_d = S_ERROR;
            err_d   = 2'b01;
          end
        end
        S_CDR_RST: begin
          if (!pll_lock) state_d = S_PLL_RST;
          else if (rst_done) state_d = S_CDR_WAIT;
        end
        S_CDR_WAIT: begin
          if (!pll_lock) state_d = S_PLL_RST;
          else if (cdr_locked) state_d = S_ACTIVE;
          else if (cnt_q == CDR_LAST) begin
            state_d = S_ERROR;
            err_d   = 2'b10;
          end
        end
        S_ACTIVE: begin
          if (!pll_lock || !cdr_lock) begin
            state_d = !pll_lock ? S_PLL_RST : S_CDR_RST;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        S_ERROR: begin
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
          if (rst_done && (32'(retry_q) < RETRY_LIMIT)) begin
            state_d = S_PLL_RST;
            retry_d = retry_q + 2'd1;
          end
`endif
        end
        default: state_d = S_OFF;
      endcase
    end
    if (state_d == S_OFF) begin
      err_d    = 2'b00;
      relock_d = 8'd0;
    end
`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
    if (state_d == S_OFF || state_d == S_ACTIVE) retry_d = 2'd0;
`endif
    if (state_d != state_q || restart_hit) cnt_d = '0;
    else cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    pll_flt_d = (state_q == S_PLL_WAIT && pll_lock) ? ((pll_flt_q == FLT_MAX) ? pll_flt_q : pll_flt_q + 1'b1) : '0;
    cdr_flt_d = (state_q == S_CDR_WAIT && cdr_lock) ? ((cdr_flt_q == FLT_MAX) ? cdr_flt_q : cdr_flt_q + 1'b1) : '0;
  end

  // Outputs are decoded from the next state so they move on the same edge as seq_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      pll_flt_q <= '0;
      cdr_flt_q <= '0;
      err_q     <= 2'b00;
      relock_q  <= 8'd0;
      iso_q     <= 1'b1;
      pll_rst_q <= 1'b1;
      cdr_rst_q <= 1'b1;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      link_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_flt_q <= pll_flt_d;
      cdr_flt_q <= cdr_flt_d;
      err_q     <= err_d;
      relock_q  <= relock_d;
      iso_q     <= (state_d == S_OFF);
      pll_rst_q <= (state_d == S_OFF) || (state_d == S_PLL_RST) || (state_d == S_ERROR);
      cdr_rst_q <= !((state_d == S_CDR_WAIT) || (state_d == S_ACTIVE));
      tx_en_q   <= (state_d == S_ACTIVE) && tx_en_req;
      rx_en_q   <= (state_d == S_ACTIVE) && rx_en_req;
      link_q    <= (state_d == S_ACTIVE);
    end
  end

`ifdef SERDESPHY_SEQ_AUTO_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= 2'd0;
    else        retry_q <= retry_d;
  end
`endif

  assign iso_out     = iso_q;
  assign pll_rst_out = pll_rst_q;
  assign cdr_rst_out = cdr_rst_q;
  assign tx_path_en  = tx_en_q;
  assign rx_path_en  = rx_en_q;
  assign link_up     = link_q;
  assign seq_state   = state_q;
  assign err_code    = err_q;
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// tb/tb_serdesphy_link_seq.sv - directed self-checking bench for serdesphy_link_seq
`timescale 1ns/1ps
module tb_serdesphy_link_seq;

  logic       clk = 1'b0;
  logic       rst_n, phy_en, seq_restart, tx_en_req, rx_en_req, pll_lock, cdr_lock;
  logic       iso_out, pll_rst_out, cdr_rst_out, tx_path_en, rx_path_en, link_up;
  logic [2:0] seq_state;
  logic [1:0] err_code;
  logic [7:0] relock_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;

  serdesphy_link_seq dut (
    .clk(clk), .rst_n(rst_n), .phy_en(phy_en), .seq_restart(seq_restart),
    .tx_en_req(tx_en_req), .rx_en_req(rx_en_req), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
    .iso_out(iso_out), .pll_rst_out(pll_rst_out), .cdr_rst_out(cdr_rst_out),
    .tx_path_en(tx_path_en), .rx_path_en(rx_path_en), .link_up(link_up),
    .seq_state(seq_state), .err_code(err_code), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; phy_en = 1'b0; seq_restart = 1'b0;
    tx_en_req = 1'b0; rx_en_req = 1'b0; pll_lock = 1'b1; cdr_lock = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phy_en = 1'b1; seq_restart = 1'b0;
    tx_en_req = 1'b1; rx_en_req = 1'b1; pll_lock = 1'b1; cdr_lock = 1'b1;
    tick(3);
    n_checks++; if (seq_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", seq_state); end
    n_checks++; if ({iso_out, pll_rst_out, cdr_rst_out} !== 3'b111) begin n_fail++; $display("FAIL reset_iso_rst: got %b expected 111", {iso_out, pll_rst_out, cdr_rst_out}); end
    n_checks++; if ({tx_path_en, rx_path_en, link_up} !== 3'b000) begin n_fail++; $display("FAIL reset_enables: got %b expected 000", {tx_path_en, rx_path_en, link_up}); end
    n_checks++; if ({err_code, relock_cnt} !== 10'd0) begin n_fail++; $display("FAIL reset_err_relock: got err=%0d relock=%0d expected 0 0", err_code, relock_cnt); end
  endtask

  task automatic test_happy_path();
    reset_dut();
    phy_en = 1'b1;
    tick(1);
    n_checks++; if ({seq_state, iso_out, pll_rst_out, cdr_rst_out} !== {3'd1, 3'b011}) begin n_fail++; $display("FAIL happy_pll_rst: got st=%0d iso/prst/crst=%b expected 1 011", seq_state, {iso_out, pll_rst_out, cdr_rst_out}); end
    tick(15);
    n_checks++; if (seq_state !== 3'd1) begin n_fail++; $display("FAIL happy_pll_rst_hold: got %0d expected 1", seq_state); end
    tick(1);
    n_checks++; if ({seq_state, pll_rst_out, cdr_rst_out} !== {3'd2, 2'b01}) begin n_fail++; $display("FAIL happy_pll_wait: got st=%0d prst/crst=%b expected 2 01", seq_state, {pll_rst_out, cdr_rst_out}); end
    tick(7);
    n_checks++; if (seq_state !== 3'd2) begin n_fail++; $display("FAIL happy_pll_filter: got %0d expected 2", seq_state); end
    tick(1);
    n_checks++; if ({seq_state, pll_rst_out, cdr_rst_out} !== {3'd3, 2'b01}) begin n_fail++; $display("FAIL happy_cdr_rst: got st=%0d prst/crst=%b expected 3 01", seq_state, {pll_rst_out, cdr_rst_out}); end
    tick(16);
    n_checks++; if ({seq_state, cdr_rst_out} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL happy_cdr_wait: got st=%0d crst=%b expected 4 0", seq_state, cdr_rst_out); end
    tick(7);
    n_checks++; if ({seq_state, link_up} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL happy_cdr_filter: got st=%0d link=%b expected 4 0", seq_state, link_up); end
    tick(1);
    n_checks++; if ({seq_state, link_up, tx_path_en} !== {3'd5, 2'b10}) begin n_fail++; $display("FAIL happy_active: got st=%0d link/tx=%b expected 5 10", seq_state, {link_up, tx_path_en}); end
    tx_en_req = 1'b1;
    rx_en_req = 1'b1;
    n_checks++; if ({tx_path_en, rx_path_en} !== 2'b00) begin n_fail++; $display("FAIL happy_tx_latency: got %b expected 00", {tx_path_en, rx_path_en}); end
    tick(1);
    n_checks++; if ({tx_path_en, rx_path_en} !== 2'b11) begin n_fail++; $display("FAIL happy_tx_follow: got %b expected 11", {tx_path_en, rx_path_en}); end
    tx_en_req = 1'b0;
    tick(1);
    n_checks++; if ({tx_path_en, rx_path_en} !== 2'b01) begin n_fail++; $display("FAIL happy_tx_drop: got %b expected 01", {tx_path_en, rx_path_en}); end
  endtask

  task automatic test_lock_loss();
    reset_dut();
    phy_en = 1'b1;
    tick(49);
    n_checks++; if (seq_state !== 3'd5) begin n_fail++; $display("FAIL loss_bringup: got %0d expected 5", seq_state); end
    cdr_lock = 1'b0;
    tick(1);
    cdr_lock = 1'b1;
    n_checks++; if ({seq_state, relock_cnt, link_up} !== {3'd3, 8'd1, 1'b0}) begin n_fail++; $display("FAIL loss_cdr: got st=%0d relock=%0d link=%b expected 3 1 0", seq_state, relock_cnt, link_up); end
    tick(24);
    n_checks++; if (seq_state !== 3'd5) begin n_fail++; $display("FAIL loss_cdr_recover: got %0d expected 5", seq_state); end
    pll_lock = 1'b0; cdr_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1; cdr_lock = 1'b1;
    n_checks++; if ({seq_state, relock_cnt} !== {3'd1, 8'd2}) begin n_fail++; $display("FAIL loss_both: got st=%0d relock=%0d expected 1 2", seq_state, relock_cnt); end
    tick(48);
    n_checks++; if (seq_state !== 3'd5) begin n_fail++; $display("FAIL loss_pll_recover: got %0d expected 5", seq_state); end
    for (int i = 0; i < 300; i++) begin
      cdr_lock = 1'b0;
      tick(1);
      cdr_lock = 1'b1;
      tick(24);
      if (i == 9) begin
        n_checks++; if (relock_cnt !== 8'd12) begin n_fail++; $display("FAIL loss_count_12: got %0d expected 12", relock_cnt); end
      end
    end
    n_checks++; if ({seq_state, relock_cnt} !== {3'd5, 8'd255}) begin n_fail++; $display("FAIL loss_saturate: got st=%0d relock=%0d expected 5 255", seq_state, relock_cnt); end
    phy_en = 1'b0;
    tick(1);
    n_checks++; if ({seq_state, relock_cnt, iso_out} !== {3'd0, 8'd0, 1'b1}) begin n_fail++; $display("FAIL loss_off_clear: got st=%0d relock=%0d iso=%b expected 0 0 1", seq_state, relock_cnt, iso_out); end
  endtask

  task automatic test_pll_timeout();
    reset_dut();
    pll_lock = 1'b0; cdr_lock = 1'b0; phy_en = 1'b1;
    tick(4112);
    n_checks++; if ({seq_state, err_code} !== {3'd2, 2'b00}) begin n_fail++; $display("FAIL pto_before: got st=%0d err=%0d expected 2 0", seq_state, err_code); end
    tick(1);
    n_checks++; if ({seq_state, err_code, iso_out, pll_rst_out} !== {3'd6, 2'b01, 2'b01}) begin n_fail++; $display("FAIL pto_error: got st=%0d err=%0d iso=%b prst=%b expected 6 1 0 1", seq_state, err_code, iso_out, pll_rst_out); end
    tick(100);
    n_checks++; if ({seq_state, err_code} !== {3'd6, 2'b01}) begin n_fail++; $display("FAIL pto_sticky: got st=%0d err=%0d expected 6 1", seq_state, err_code); end
    seq_restart = 1'b1;
    tick(1);
    seq_restart = 1'b0;
    n_checks++; if ({seq_state, err_code} !== {3'd1, 2'b00}) begin n_fail++; $display("FAIL pto_restart: got st=%0d err=%0d expected 1 0", seq_state, err_code); end
  endtask

  task automatic test_lock_filter();
    reset_dut();
    pll_lock = 1'b0; phy_en = 1'b1;
    tick(17);
    for (int i = 0; i < 40; i++) begin
      pll_lock = 1'b1;
      tick(7);
      pll_lock = 1'b0;
      tick(1);
    end
    n_checks++; if (seq_state !== 3'd2) begin n_fail++; $display("FAIL filter_glitchy: got %0d expected 2", seq_state); end
    pll_lock = 1'b1;
    tick(7);
    n_checks++; if (seq_state !== 3'd2) begin n_fail++; $display("FAIL filter_seven: got %0d expected 2", seq_state); end
    tick(1);
    n_checks++; if (seq_state !== 3'd3) begin n_fail++; $display("FAIL filter_eighth: got %0d expected 3", seq_state); end
  endtask

  task automatic test_cdr_timeout_priority();
    reset_dut();
    pll_lock = 1'b1; cdr_lock = 1'b0; phy_en = 1'b1;
    tick(41);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL prio_cdr_wait: got %0d expected 4", seq_state); end
    tick(8191);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    n_checks++; if ({seq_state, err_code} !== {3'd1, 2'b00}) begin n_fail++; $display("FAIL prio_pll_over_timeout: got st=%0d err=%0d expected 1 0", seq_state, err_code); end
    tick(40);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL cto_reenter: got %0d expected 4", seq_state); end
    tick(8191);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL cto_before: got %0d expected 4", seq_state); end
    tick(1);
    n_checks++; if ({seq_state, err_code, iso_out} !== {3'd6, 2'b10, 1'b0}) begin n_fail++; $display("FAIL cto_error: got st=%0d err=%0d iso=%b expected 6 2 0", seq_state, err_code, iso_out); end
    phy_en = 1'b0; seq_restart = 1'b1;
    tick(1);
    seq_restart = 1'b0;
    n_checks++; if ({seq_state, err_code, iso_out} !== {3'd0, 2'b00, 1'b1}) begin n_fail++; $display("FAIL prio_off_over_restart: got st=%0d err=%0d iso=%b expected 0 0 1", seq_state, err_code, iso_out); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    cdr_lock = 1'b0; phy_en = 1'b1;
    tick(41);
    n_checks++; if (seq_state !== 3'd4) begin n_fail++; $display("FAIL async_setup: got %0d expected 4", seq_state); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({seq_state, iso_out, pll_rst_out, cdr_rst_out, link_up} !== {3'd0, 4'b1110}) begin n_fail++; $display("FAIL async_reset: got st=%0d iso/prst/crst/link=%b expected 0 1110", seq_state, {iso_out, pll_rst_out, cdr_rst_out, link_up}); end
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_lock_loss();
    test_pll_timeout();
    test_lock_filter();
    test_cdr_timeout_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serdesphy_link_seq.md
Name: serdesphy_link_seq

Overview:
Link bring-up sequencer between the CSR block and the PHY analog/CDR blocks. It takes the static CSR enables and the raw lock indicators, then drives the PHY through its power-up sequence:
- isolation release
- PLL reset and lock
- CDR reset and lock
- datapath enable

It also re-runs the sequence on lock loss, detects lock timeouts, and reports sequencer state and error codes for the CSR STATUS/debug readback.

Parameters:
RST_HOLD_CYCLES, 16, cycles pll_rst/cdr_rst are held asserted per reset phase (>=1)
LOCK_FILTER, 8, consecutive cycles a lock input must be high to count as locked (>=1)
PLL_LOCK_TIMEOUT, 4096, max cycles in PLL_WAIT before error
CDR_LOCK_TIMEOUT, 8192, max cycles in CDR_WAIT before error
RETRY_LIMIT, 3, auto-retry attempts (used only with optional feature)

Ports:
clk  input  1  system clock (24 MHz)
rst_n  input  1  reset; asynchronous, active-low
phy_en  input  1  CSR PHY global enable (level)
seq_restart  input  1  single-cycle pulse; restart sequence
tx_en_req  input  1  CSR tx_en
rx_en_req  input  1  CSR rx_en
pll_lock  input  1  raw PLL lock (already synchronised)
cdr_lock  input  1  raw CDR lock (already synchronised)
iso_out  output  1  analog isolation (1 = isolated)
pll_rst_out  output  1  PLL reset to analog
cdr_rst_out  output  1  CDR reset
tx_path_en  output  1  TX datapath enable
rx_path_en  output  1  RX datapath enable
link_up  output  1  high only in ACTIVE
seq_state  output  3  current state encoding
err_code  output  2  00 none, 01 PLL timeout, 10 CDR timeout; sticky
relock_cnt  output  8  saturating count of lock losses while ACTIVE

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- All outputs are registered. They are decoded from the next state, so they change on the same edge as seq_state.
- Reset values: state OFF, iso_out=1, pll_rst_out=1, cdr_rst_out=1, tx/rx_path_en=0, link_up=0, err_code=00, relock_cnt=0.
- State encodings: OFF=0, PLL_RST=1, PLL_WAIT=2, CDR_RST=3, CDR_WAIT=4, ACTIVE=5, ERROR=6.
- Transition priority, evaluated per edge:
  1. phy_en=0 sends any state to OFF.
  2. seq_restart=1 sends any state except OFF to PLL_RST; it also clears err_code and the retry count.
  3. State-specific rules below.
- A single state counter clears on every state entry. Lock filter counters clear whenever their lock input is 0.
- OFF:
  - iso=1, both resets=1, enables=0. relock_cnt and err_code are cleared.
  - phy_en=1 goes to PLL_RST.
- PLL_RST:
  - iso=0, pll_rst=1, cdr_rst=1.
  - Leaves to PLL_WAIT after exactly RST_HOLD_CYCLES cycles in state.
- PLL_WAIT:
  - pll_rst=0.
  - Filtered pll_lock (LOCK_FILTER consecutive highs) goes to CDR_RST.
  - Counter reaching PLL_LOCK_TIMEOUT without filtered lock goes to ERROR with err_code=01.
  - If filtered lock and timeout occur on the same cycle, lock wins.
- CDR_RST:
  - cdr_rst=1 for RST_HOLD_CYCLES cycles, then CDR_WAIT.
  - pll_lock=0 at any cycle goes to PLL_RST.
- CDR_WAIT:
  - cdr_rst=0.
  - Filtered cdr_lock goes to ACTIVE.
  - Timeout at CDR_LOCK_TIMEOUT goes to ERROR with err_code=10.
  - pll_lock=0 goes to PLL_RST; this takes precedence over cdr_lock and timeout.
- ACTIVE:
  - link_up=1. tx_path_en=tx_en_req and rx_path_en=rx_en_req, with 1-cycle register latency.
  - pll_lock=0 goes to PLL_RST; cdr_lock=0 goes to CDR_RST. Either case increments relock_cnt, which saturates at 255.
  - If both locks drop in the same cycle, go to PLL_RST with a single increment.
- ERROR:
  - Outputs as OFF, except iso_out=0.
  - err_code holds. The block stays here until seq_restart or phy_en=0.
- Timeout counters are wide enough for the largest timeout (clog2). No wrap-around is possible, because the state exits at terminal count.
- If rst_n asserts mid-sequence, outputs go to reset values immediately (asynchronous).

Optional Feature:
SERDESPHY_SEQ_AUTO_RETRY_EN:
- Defined:
  - ERROR automatically goes to PLL_RST after RST_HOLD_CYCLES cycles, up to RETRY_LIMIT times. A 2-bit retry count increments on each auto-retry.
  - After the limit is reached, the block stays in ERROR.
  - The retry count clears on reaching ACTIVE, on OFF and on seq_restart.
  - err_code holds the latest timeout cause until cleared.
- Undefined: ERROR exits only via seq_restart or phy_en=0. No retry logic is synthesised.

Test Plan:
- Happy path: rst_n released, pll_lock and cdr_lock tied 1, phy_en rises, first sampled at edge 0.
  - -> PLL_WAIT after edge 16, CDR_RST after edge 24, CDR_WAIT after edge 40, link_up=1 after edge 48.
  - -> tx_path_en follows tx_en_req one cycle later.
- PLL timeout: pll_lock=0, phy_en=1 at edge 0.
  - -> ERROR with err_code=01 after edge 4112. iso_out=0, pll_rst_out=1.
  - -> seq_restart pulse returns to PLL_RST with err_code=00.
- Lock filter: pll_lock toggles high 7 cycles / low 1 cycle in PLL_WAIT.
  - -> never leaves PLL_WAIT before timeout.
  - -> 8th consecutive high advances to CDR_RST.
- Lock loss in ACTIVE: drop cdr_lock for 1 cycle.
  - -> CDR_RST next edge, relock_cnt=1, link_up=0.
  - -> then drop both locks together: PLL_RST, relock_cnt=2.
  - -> 300 losses: relock_cnt=255.
- Priority: in CDR_WAIT at timeout cycle with pll_lock=0 -> PLL_RST, err_code stays 00. phy_en=0 with seq_restart=1 on the same edge -> OFF.
- With SERDESPHY_SEQ_AUTO_RETRY_EN and cdr_lock=0: three auto-retries, then the block remains in ERROR with err_code=10. Also assert rst_n mid-CDR_WAIT -> all outputs reset immediately.
